// File: rtl/scurve_stream_parser.sv
// scurve_stream_parser: rebuilds one record per DAC step from the 16-bit
// S-curve result stream (header, channel, DAC + trigger words, end word).
// Ports:
//   Clk, reset          system clock, asynchronous active-high reset
//   Parser_Enable       level enable; low forces IDLE and clears Error_Flags
//   stream_fifo_empty   source FIFO empty
//   stream_fifo_dout    FIFO read data, valid the cycle after rd_en
//   stream_fifo_rd_en   single-cycle read strobe
//   Record_Valid/Ready  record handshake; fields held while Valid=1
//   Record_Single       1 = single-channel scan (0x43xx), 0 = 64-channel (0x63xx)
//   Record_Chn          channel of the record
//   Record_DAC_Code     DAC code of the step
//   Record_Word_Count   trigger words in the step (saturating)
//   Record_Trig_Sum     sum of trigger words in the step (saturating)
//   Scan_Done           one-cycle pulse after the end word is processed
//   Error_Flags         sticky: [0] word out of order, [1] DAC sequence,
//                       [2] channel sequence, [3] count/sum saturated
module scurve_stream_parser #(
    parameter int DAC_MAX = 1023,
    parameter int CHN_MAX = 63,
    parameter int SUM_W   = 24
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             Parser_Enable,
    input  logic             stream_fifo_empty,
    input  logic [15:0]      stream_fifo_dout,
    output logic             stream_fifo_rd_en,
    output logic             Record_Valid,
    input  logic             Record_Ready,
    output logic             Record_Single,
    output logic [5:0]       Record_Chn,
    output logic [9:0]       Record_DAC_Code,
    output logic [15:0]      Record_Word_Count,
    output logic [SUM_W-1:0] Record_Trig_Sum,
    output logic             Scan_Done,
    output logic [3:0]       Error_Flags
);

    localparam logic [9:0] DAC_LAST = 10'(DAC_MAX);
    localparam logic [5:0] CHN_LAST = 6'(CHN_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_DECODE, S_WAIT_ACK
    } state_t;

    typedef enum logic [1:0] {
        P_EXP_HEADER, P_EXP_CHN, P_EXP_DAC, P_IN_DATA
    } phase_t;

    typedef enum logic [2:0] {
        W_END, W_CHN, W_DAC, W_HDR, W_DATA
    } wclass_t;

    state_t  state, state_nxt;
    phase_t  phase;
    wclass_t wclass;

    logic [15:0]      word_reg;
    logic             step_open;
    logic             first_chn;
    logic [10:0]      exp_dac;
    logic             single_q;
    logic [5:0]       chn_q;
    logic [9:0]       dac_q;
    logic [15:0]      cnt_q;
    logic [SUM_W-1:0] sum_q;
    logic [3:0]       err_q;
    logic             done_q;

    logic             closes;
    logic             act;
    logic             do_hdr, do_chn, do_dac, do_data, do_end, do_bad;
    logic             new_single;
    logic [5:0]       new_chn;
    logic [6:0]       chn_next;
    logic             chn_seq_bad;
    logic [16:0]      cnt_inc;
    logic [SUM_W:0]   sum_inc;

    // Word classification, in priority order.
    always_comb begin
        if (word_reg == 16'hFF45)
            wclass = W_END;
        else if ((word_reg[15:8] == 8'h43 || word_reg[15:8] == 8'h63)
                 && word_reg[7:6] == 2'b00)
            wclass = W_CHN;
        else if (word_reg[15:12] == 4'hD && word_reg[11:10] == 2'b00)
            wclass = W_DAC;
        else if (word_reg == 16'h5343)
            wclass = W_HDR;
        else
            wclass = W_DATA;
    end

    // A DAC/CHN/END word arriving with a step open first emits that step's
    // record; the same word is decoded again once the record is taken.
    assign closes = step_open && (phase == P_IN_DATA)
                    && (wclass != W_DATA) && (wclass != W_HDR);

    assign act = (state == S_DECODE) && Parser_Enable && !closes;

    always_comb begin
        do_hdr  = 1'b0;
        do_chn  = 1'b0;
        do_dac  = 1'b0;
        do_data = 1'b0;
        do_end  = 1'b0;
        do_bad  = 1'b0;
        if (act) begin
            unique case (phase)
                P_EXP_HEADER: begin
                    if (wclass == W_HDR) do_hdr = 1'b1;
                    else                 do_bad = 1'b1;
                end
                P_EXP_CHN: begin
                    if (wclass == W_CHN) do_chn = 1'b1;
                    else                 do_bad = 1'b1;
                end
                P_EXP_DAC: begin
                    if (wclass == W_DAC) do_dac = 1'b1;
                    else                 do_bad = 1'b1;
                end
                P_IN_DATA: begin
                    unique case (wclass)
                        W_DATA:  do_data = 1'b1;
                        W_DAC:   do_dac  = 1'b1;
                        W_CHN:   do_chn  = 1'b1;
                        W_END:   do_end  = 1'b1;
                        default: do_bad  = 1'b1;
                    endcase
                end
            endcase
        end
    end

    // Channel word fields and 64-channel sequence check. One extra bit
    // keeps 63+1 from wrapping back onto channel 0.
    assign new_single  = (word_reg[15:8] == 8'h43);
    assign new_chn     = word_reg[5:0];
    assign chn_next    = first_chn ? 7'd0 : ({1'b0, chn_q} + 7'd1);
    assign chn_seq_bad = !new_single && ({1'b0, new_chn} != chn_next);

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign sum_inc = {1'b0, sum_q} + (SUM_W+1)'(word_reg);

    // FSM: state register
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (!Parser_Enable) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:     state_nxt = S_FETCH;
                S_FETCH:    if (!stream_fifo_empty) state_nxt = S_CAPTURE;
                S_CAPTURE:  state_nxt = S_DECODE;
                S_DECODE:   state_nxt = closes ? S_WAIT_ACK : S_FETCH;
                S_WAIT_ACK: if (Record_Ready) state_nxt = S_DECODE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        stream_fifo_rd_en = 1'b0;
        Record_Valid      = 1'b0;
        unique case (state)
            S_FETCH:    stream_fifo_rd_en = Parser_Enable && !stream_fifo_empty;
            S_WAIT_ACK: Record_Valid = 1'b1;
            default:    ;
        endcase
    end

    // Datapath: captured word, phase, step record and sticky flags.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            phase     <= P_EXP_HEADER;
            word_reg  <= '0;
            step_open <= 1'b0;
            first_chn <= 1'b0;
            exp_dac   <= '0;
            single_q  <= 1'b0;
            chn_q     <= '0;
            dac_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else if (!Parser_Enable || state == S_IDLE) begin
            phase     <= P_EXP_HEADER;
            word_reg  <= '0;
            step_open <= 1'b0;
            first_chn <= 1'b0;
            exp_dac   <= '0;
            single_q  <= 1'b0;
            chn_q     <= '0;
            dac_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state == S_CAPTURE)
                word_reg <= stream_fifo_dout;

            if (state == S_WAIT_ACK && Record_Ready)
                step_open <= 1'b0;

            if (do_hdr) begin
                phase     <= P_EXP_CHN;
                first_chn <= 1'b1;
            end

            if (do_chn) begin
                // A new channel mid-scan: previous channel must have finished.
                if (phase == P_IN_DATA) begin
                    if (dac_q != DAC_LAST) err_q[1] <= 1'b1;
                    if (single_q)          err_q[2] <= 1'b1;
                end
                if (chn_seq_bad) err_q[2] <= 1'b1;
                single_q  <= new_single;
                chn_q     <= new_chn;
                first_chn <= 1'b0;
                exp_dac   <= '0;
                phase     <= P_EXP_DAC;
            end

            if (do_dac) begin
                if ({1'b0, word_reg[9:0]} != exp_dac) err_q[1] <= 1'b1;
                dac_q     <= word_reg[9:0];
                cnt_q     <= '0;
                sum_q     <= '0;
                step_open <= 1'b1;
                exp_dac   <= {1'b0, word_reg[9:0]} + 11'd1;
                phase     <= P_IN_DATA;
            end

            if (do_data) begin
                if (cnt_inc[16]) begin
                    cnt_q    <= '1;
                    err_q[3] <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc[15:0];
                end
                if (sum_inc[SUM_W]) begin
                    sum_q    <= '1;
                    err_q[3] <= 1'b1;
                end else begin
                    sum_q <= sum_inc[SUM_W-1:0];
                end
            end

            if (do_end) begin
                if (dac_q != DAC_LAST)                err_q[1] <= 1'b1;
                if (!single_q && chn_q != CHN_LAST)   err_q[2] <= 1'b1;
                done_q <= 1'b1;
                phase  <= P_EXP_HEADER;
            end

            if (do_bad) err_q[0] <= 1'b1;
        end
    end

    assign Record_Single     = single_q;
    assign Record_Chn        = chn_q;
    assign Record_DAC_Code   = dac_q;
    assign Record_Word_Count = cnt_q;
    assign Record_Trig_Sum   = sum_q;
    assign Scan_Done         = done_q;
    assign Error_Flags       = err_q;

endmodule
